div_result_reconstructor: RTL
=============================

// Module: div_result_reconstructor
// PURPOSE
//  Inverse of the fast divider: rebuilds dividend = quotient*divisor + remainder
//  with a sequential shift-add multiplier, one multiplier bit per clock.
//  Compares the rebuilt value with an expected dividend and flags illegal results.
//  Sits downstream of the divider as a self-check and result-verification stage.
// PARAMETERS
//  WIDTH  8  width of quotient, divisor and remainder; dividend is 2*WIDTH bits
// PORTS
//  clk           in   1        single clock; all state updates on rising edge
//  rst           in   1        reset, synchronous, active-high
//  start         in   1        request; sampled only when busy==0
//  quotient      in   WIDTH    multiplier operand
//  divisor       in   WIDTH    multiplicand operand
//  remainder     in   WIDTH    addend operand
//  exp_dividend  in   2*WIDTH  expected dividend used for the mismatch check
//  dividend      out  2*WIDTH  rebuilt dividend; registered, held until next result
//  busy          out  1        high while in MUL
//  done          out  1        one-cycle pulse; dividend and flags are valid
//  mismatch      out  1        dividend != captured exp_dividend; valid with done, held
//  rem_err       out  1        captured remainder >= captured divisor; valid with done, held
//  div_zero      out  1        captured divisor == 0; valid with done, held
// BEHAVIOUR
//  - Reset (sync): state=IDLE; all outputs 0; internal registers 0.
//  - FSM states:
//    - IDLE -> MUL on start.
//    - MUL -> DONE after WIDTH iterations.
//    - DONE -> MUL if start is high in the DONE cycle, else -> IDLE.
//  - busy=0 in IDLE and DONE, so start is accepted in both states.
//  - Start is ignored while busy=1: no capture and no effect on the operation in flight.
//  - On an accepted start, capture quotient->mplr, divisor zero-extended to 2*WIDTH->mcand,
//    and exp_dividend.
//  - Also on start: acc = zero-extended remainder; cnt = 0.
//  - Also on start: latch rem_err_c = (remainder >= divisor) and div_zero_c = (divisor == 0).
//  - MUL iteration (each cycle): if mplr[0], acc <= acc + mcand; then mcand <<= 1,
//    mplr >>= 1, cnt++.
//  - Exactly WIDTH iterations always; no early exit on zero multiplier.
//  - Arithmetic is modulo 2^(2*WIDTH).
//  - Overflow is impossible: max (2^W-1)^2 + 2^W-1 < 2^(2W).
//  - Latency: start sampled at edge E0; the cycle after edge E(WIDTH+1) is DONE.
//    - done=1 there for exactly one cycle.
//    - Start-to-done = WIDTH+1 clocks (9 for WIDTH=8).
//  - On entering DONE, register dividend=acc, mismatch=(acc!=exp_c), rem_err, div_zero.
//    All are held until the next entry to DONE.
//  - Back-to-back: start during DONE begins a new operation.
//    - The previous outputs stay held; busy rises next cycle.
//  - divisor==0: product is 0, so dividend=remainder. div_zero=1 and rem_err=1
//    (remainder >= 0 is always true).
//  - rem_err/div_zero are informational only; the computation always completes.
//  - Reset mid-operation: aborts the operation and returns to IDLE.
//    - No done pulse; dividend and flags are cleared to 0.
//  - start and rst in the same cycle: reset wins.
// TESTING
//  1. q=0x6B, d=0x66, r=0x22, exp=0x2AC4 -> done 9 clks after start;
//     dividend=0x2AC4, mismatch=0, rem_err=0, div_zero=0.
//  2. q=0xFF, d=0xFF, r=0xFE, exp=0xFEFF -> dividend=0xFEFF (max, no overflow), all flags 0.
//  3. q=0x12, d=0x00, r=0x05, exp=0x0005 -> dividend=0x0005, div_zero=1, rem_err=1, mismatch=0.
//  4. q=0x03, d=0x04, r=0x05, exp=0x0010 -> dividend=0x0011, rem_err=1, mismatch=1.
//  5. Start, pulse start again at clks 3 and 5 (busy=1) -> ignored; single done at clk 9 with
//     result of the first operands. Then start in the DONE cycle -> next done 9 clks later.
//  6. Start case 1, assert rst at clk 4 -> no done; dividend=0, flags=0, busy=0.
//     A fresh start afterwards gives a correct result.

Source files
------------

// File: rtl/div_result_reconstructor_if.sv
// Request/result bundle between the divider self-check stage and its driver.
interface div_result_reconstructor_if #(parameter int WIDTH = 8);
  logic               start;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   remainder;
  logic [2*WIDTH-1:0] exp_dividend;
  logic [2*WIDTH-1:0] dividend;
  logic               busy;
  logic               done;
  logic               mismatch;
  logic               rem_err;
  logic               div_zero;

  modport master (
    output start, quotient, divisor, remainder, exp_dividend,
    input  dividend, busy, done, mismatch, rem_err, div_zero
  );

  modport slave (
    input  start, quotient, divisor, remainder, exp_dividend,
    output dividend, busy, done, mismatch, rem_err, div_zero
  );
endinterface

// File: rtl/div_result_reconstructor.sv
// Rebuilds dividend = quotient*divisor + remainder with a one-bit-per-clock
// shift-add multiplier and flags mismatching or illegal divider results.
module div_result_reconstructor #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  div_result_reconstructor_if.slave   bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [DW-1:0]    mcand_q, mcand_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    exp_q, exp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rem_err_c_q, rem_err_c_d;
  logic             div_zero_c_q, div_zero_c_d;
  logic [DW-1:0]    dividend_q, dividend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic             rem_err_q, rem_err_d;
  logic             div_zero_q, div_zero_d;
  logic             accept;

  // Start is only honoured when not multiplying, i.e. in IDLE or DONE.
  assign accept = bus.start && (state_q != MUL);

  always_comb begin
    state_d      = state_q;
    mplr_d       = mplr_q;
    mcand_d      = mcand_q;
    acc_d        = acc_q;
    exp_d        = exp_q;
    cnt_d        = cnt_q;
    rem_err_c_d  = rem_err_c_q;
    div_zero_c_d = div_zero_c_q;
    dividend_d   = dividend_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mismatch_d   = mismatch_q;
    rem_err_d    = rem_err_q;
    div_zero_d   = div_zero_q;

    case (state_q)
      IDLE: ;
      MUL: begin
        if (cnt_q == CW'(WIDTH)) begin
          // Accumulator is final: publish result and flags together with done.
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          dividend_d = acc_q;
          mismatch_d = (acc_q != exp_q);
          rem_err_d  = rem_err_c_q;
          div_zero_d = div_zero_c_q;
        end else begin
          if (mplr_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d      = MUL;
      busy_d       = 1'b1;
      mplr_d       = bus.quotient;
      mcand_d      = DW'(bus.divisor);
      acc_d        = DW'(bus.remainder);
      exp_d        = bus.exp_dividend;
      cnt_d        = '0;
      rem_err_c_d  = (bus.remainder >= bus.divisor);
      div_zero_c_d = (bus.divisor == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mplr_q       <= '0;
      mcand_q      <= '0;
      acc_q        <= '0;
      exp_q        <= '0;
      cnt_q        <= '0;
      rem_err_c_q  <= 1'b0;
      div_zero_c_q <= 1'b0;
      dividend_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      rem_err_q    <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mplr_q       <= mplr_d;
      mcand_q      <= mcand_d;
      acc_q        <= acc_d;
      exp_q        <= exp_d;
      cnt_q        <= cnt_d;
      rem_err_c_q  <= rem_err_c_d;
      div_zero_c_q <= div_zero_c_d;
      dividend_q   <= dividend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mismatch_q   <= mismatch_d;
      rem_err_q    <= rem_err_d;
      div_zero_q   <= div_zero_d;
    end
  end

  assign bus.dividend = dividend_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mismatch = mismatch_q;
  assign bus.rem_err  = rem_err_q;
  assign bus.div_zero = div_zero_q;
endmodule
